// File: rtl/spike_count_decoder.sv
// Spike-count output decoder: per-neuron counters over one window,
// then a sequential argmax presented with a valid/ack handshake.
module spike_count_decoder #(
  parameter int N_OUT        = 2,
  parameter int N_CYCLES     = 10,
  parameter int CYCLES_CNT_W = 5,
  parameter int SPK_CNT_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       in_valid,
  input  logic [N_OUT-1:0]           in_spikes,
  input  logic                       result_ack,
  output logic                       busy,
  output logic                       class_valid,
  output logic [$clog2(N_OUT)-1:0]   class_idx,
  output logic                       tie,
  output logic                       no_spike,
  output logic [N_OUT*SPK_CNT_W-1:0] counts
);

  localparam int IDX_W = $clog2(N_OUT);
  localparam int K_W   = $clog2(N_OUT + 1);
  localparam logic [SPK_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CYCLES_CNT_W-1:0] T_LAST =
    CYCLES_CNT_W'(N_CYCLES - 1);
  localparam logic [K_W-1:0] K_FIN = K_W'(N_OUT);

  typedef enum logic [1:0] {
    IDLE, ACCUM, DECIDE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [SPK_CNT_W-1:0]    cnt_q [N_OUT];
  logic [SPK_CNT_W-1:0]    cnt_d [N_OUT];
  logic [CYCLES_CNT_W-1:0] tcnt_q, tcnt_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [SPK_CNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic                    tie_r_q, tie_r_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tie_q, tie_d;
  logic                    nsp_q, nsp_d;
  logic [SPK_CNT_W-1:0]    cur_cnt;
  logic                    last_step;
  logic                    scan_fin;

  assign last_step = in_valid && (tcnt_q == T_LAST);
  assign scan_fin  = (k_q == K_FIN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (frame_start) state_d = ACCUM;
      ACCUM:
        if (frame_start)    state_d = ACCUM;
        else if (last_step) state_d = DECIDE;
      DECIDE:
        if (frame_start)   state_d = ACCUM;
        else if (scan_fin) state_d = DONE;
      DONE:
        if (frame_start)     state_d = ACCUM;
        else if (result_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ACCUM) ||
                  (state_q == DECIDE);
    class_valid = (state_q == DONE);
    class_idx   = idx_q;
    tie         = tie_q;
    no_spike    = nsp_q;
  end

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < N_OUT; i++)
      if (k_q == K_W'(i)) cur_cnt = cnt_q[i];
  end

  // One extra finalize step after the scan latches the result,
  // so the presented outputs never show intermediate scan values.
  always_comb begin
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    k_d        = k_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    tie_r_d    = tie_r_q;
    idx_d      = idx_q;
    tie_d      = tie_q;
    nsp_d      = nsp_q;
    if (frame_start) begin
      for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
      tcnt_d = '0;
      k_d    = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < N_OUT; i++)
              if (in_spikes[i] && cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
            tcnt_d = tcnt_q + 1'b1;
            k_d    = '0;
          end
        end
        DECIDE: begin
          if (scan_fin) begin
            nsp_d = (best_cnt_q == '0);
            idx_d = nsp_d ? '0 : best_idx_q;
            tie_d = nsp_d ? 1'b1 : tie_r_q;
          end else begin
            if (k_q == '0) begin
              best_idx_d = '0;
              best_cnt_d = cur_cnt;
              tie_r_d    = 1'b0;
            end else if (cur_cnt > best_cnt_q) begin
              best_idx_d = IDX_W'(k_q);
              best_cnt_d = cur_cnt;
              tie_r_d    = 1'b0;
            end else if (cur_cnt == best_cnt_q) begin
              tie_r_d = 1'b1;
            end
            k_d = k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      tcnt_q     <= '0;
      k_q        <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      tie_r_q    <= 1'b0;
      idx_q      <= '0;
      tie_q      <= 1'b0;
      nsp_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_d[i];
      tcnt_q     <= tcnt_d;
      k_q        <= k_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      tie_r_q    <= tie_r_d;
      idx_q      <= idx_d;
      tie_q      <= tie_d;
      nsp_q      <= nsp_d;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    assign counts[g*SPK_CNT_W +: SPK_CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_spike_count_decoder.sv
// Directed bench for spike_count_decoder; a second instance
// with 3-bit counters covers saturation.
module tb_spike_count_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       in_valid;
  logic [1:0] in_spikes;
  logic       result_ack;

  logic       busy, class_valid, class_idx, tie, no_spike;
  logic [9:0] counts;
  logic       busy_s, valid_s, idx_s, tie_s, nsp_s;
  logic [5:0] counts_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spike_count_decoder #(
    .N_OUT(2), .N_CYCLES(10),
    .CYCLES_CNT_W(5), .SPK_CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start),
    .in_valid(in_valid),
    .in_spikes(in_spikes),
    .result_ack(result_ack),
    .busy(busy),
    .class_valid(class_valid),
    .class_idx(class_idx),
    .tie(tie),
    .no_spike(no_spike),
    .counts(counts)
  );

  spike_count_decoder #(
    .N_OUT(2), .N_CYCLES(10),
    .CYCLES_CNT_W(5), .SPK_CNT_W(3)
  ) dut_s (
    .clk(clk), .rst(rst),
    .frame_start(frame_start),
    .in_valid(in_valid),
    .in_spikes(in_spikes),
    .result_ack(result_ack),
    .busy(busy_s),
    .class_valid(valid_s),
    .class_idx(idx_s),
    .tie(tie_s),
    .no_spike(nsp_s),
    .counts(counts_s)
  );

  task automatic cyc(input logic fs, input logic v,
                     input logic [1:0] sp, input logic ack);
    frame_start = fs;
    in_valid    = v;
    in_spikes   = sp;
    result_ack  = ack;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_spikes   = 2'b00;
    result_ack  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(0, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 0);
    rst = 1'b0;
    checks++;
    if ({busy, class_valid, class_idx, tie, no_spike} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {busy, class_valid, class_idx, tie, no_spike});
    end
    checks++;
    if (counts !== 10'd0) begin
      errors++;
      $display("FAIL reset_counts got %h exp 000", counts);
    end
  endtask

  task automatic test_basic;
    logic [3:0] vhist;
    cyc(1, 0, 2'b00, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b exp 1", busy);
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'b10, 0);
    vhist[0] = class_valid;
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 2'b00, 0);
      vhist[i] = class_valid;
    end
    checks++;
    if (vhist !== 4'b1000) begin
      errors++;
      $display("FAIL basic_latency got %b exp 1000", vhist);
    end
    checks++;
    if (counts !== {5'd10, 5'd0}) begin
      errors++;
      $display("FAIL basic_counts got %h exp %h",
               counts, {5'd10, 5'd0});
    end
    checks++;
    if ({class_idx, tie, no_spike, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_result got %b exp 1000",
               {class_idx, tie, no_spike, busy});
    end
    cyc(0, 0, 2'b00, 1);
    checks++;
    if ({class_valid, busy, class_idx} !== 3'b001) begin
      errors++;
      $display("FAIL basic_ack got %b exp 001",
               {class_valid, busy, class_idx});
    end
    cyc(0, 1, 2'b11, 0);
    checks++;
    if ({busy, counts} !== {1'b0, 5'd10, 5'd0}) begin
      errors++;
      $display("FAIL idle_ignores_valid got %h", {busy, counts});
    end
  endtask

  task automatic test_tie_gaps;
    logic [2:0] vhist;
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2'b11, 0);
      if (i < 9 && i[0]) begin
        cyc(0, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'b00, 0);
      vhist[i] = class_valid;
    end
    checks++;
    if (vhist !== 3'b100) begin
      errors++;
      $display("FAIL tie_latency got %b exp 100", vhist);
    end
    checks++;
    if (counts !== {5'd10, 5'd10}) begin
      errors++;
      $display("FAIL tie_counts got %h exp %h",
               counts, {5'd10, 5'd10});
    end
    checks++;
    if ({class_idx, tie, no_spike} !== 3'b010) begin
      errors++;
      $display("FAIL tie_result got %b exp 010",
               {class_idx, tie, no_spike});
    end
    cyc(0, 0, 2'b00, 1);
  endtask

  task automatic test_no_spike;
    logic held;
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'b00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0);
    checks++;
    if ({class_valid, class_idx, tie, no_spike} !== 4'b1011) begin
      errors++;
      $display("FAIL nospike_result got %b exp 1011",
               {class_valid, class_idx, tie, no_spike});
    end
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 2'b11, 0);
      if (class_valid !== 1'b1 || no_spike !== 1'b1 ||
          counts !== 10'd0)
        held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL nospike_hold got %b exp 1", held);
    end
    cyc(0, 0, 2'b00, 1);
  endtask

  task automatic test_saturation;
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'b01, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0);
    checks++;
    if (counts_s !== {3'd0, 3'd7}) begin
      errors++;
      $display("FAIL sat_counts got %h exp %h",
               counts_s, {3'd0, 3'd7});
    end
    checks++;
    if ({valid_s, idx_s, tie_s, nsp_s} !== 4'b1000) begin
      errors++;
      $display("FAIL sat_result got %b exp 1000",
               {valid_s, idx_s, tie_s, nsp_s});
    end
    checks++;
    if (counts !== {5'd0, 5'd10}) begin
      errors++;
      $display("FAIL nosat_counts got %h exp %h",
               counts, {5'd0, 5'd10});
    end
    cyc(0, 0, 2'b00, 1);
  endtask

  task automatic test_restart;
    logic vseen;
    vseen = 1'b0;
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b01, 0);
    cyc(0, 0, 2'b00, 1);
    checks++;
    if ({busy, counts} !== {1'b1, 5'd0, 5'd4}) begin
      errors++;
      $display("FAIL ack_in_accum got %h", {busy, counts});
    end
    cyc(1, 1, 2'b11, 0);
    checks++;
    if ({busy, counts} !== {1'b1, 10'd0}) begin
      errors++;
      $display("FAIL restart_accum got %h exp 400",
               {busy, counts});
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2'b10, 0);
      vseen |= class_valid;
    end
    cyc(0, 0, 2'b00, 0);
    vseen |= class_valid;
    cyc(1, 0, 2'b00, 0);
    checks++;
    if ({busy, class_valid, counts} !== {2'b10, 10'd0}) begin
      errors++;
      $display("FAIL restart_decide got %h",
               {busy, class_valid, counts});
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 2'b00, 0);
      vseen |= class_valid;
    end
    checks++;
    if (vseen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_valid got %b exp 0", vseen);
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'b01, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0);
    checks++;
    if (class_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got %b exp 1", class_valid);
    end
    cyc(1, 0, 2'b00, 1);
    checks++;
    if ({busy, class_valid, counts} !== {2'b10, 10'd0}) begin
      errors++;
      $display("FAIL restart_in_done got %h",
               {busy, class_valid, counts});
    end
    for (int i = 0; i < 7; i++) cyc(0, 1, 2'b10, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b11, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0);
    checks++;
    if ({class_valid, counts} !== {1'b1, 5'd10, 5'd3}) begin
      errors++;
      $display("FAIL restart_window got %h exp %h",
               {class_valid, counts}, {1'b1, 5'd10, 5'd3});
    end
    checks++;
    if ({class_idx, tie, no_spike} !== 3'b100) begin
      errors++;
      $display("FAIL restart_result got %b exp 100",
               {class_idx, tie, no_spike});
    end
    cyc(0, 0, 2'b00, 1);
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 2'b11, 0);
    rst = 1'b1;
    cyc(0, 1, 2'b11, 0);
    rst = 1'b0;
    checks++;
    if ({busy, class_valid, class_idx, tie, no_spike, counts}
        !== 15'd0) begin
      errors++;
      $display("FAIL rst_mid got %h exp 0",
               {busy, class_valid, class_idx, tie, no_spike, counts});
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b11, 0);
    checks++;
    if ({busy, counts} !== 11'd0) begin
      errors++;
      $display("FAIL rst_idle_ignore got %h exp 0", {busy, counts});
    end
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'b01, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0);
    checks++;
    if ({class_valid, class_idx, counts} !==
        {2'b10, 5'd0, 5'd10}) begin
      errors++;
      $display("FAIL rst_recover got %h",
               {class_valid, class_idx, counts});
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_spikes   = 2'b00;
    result_ack  = 1'b0;
    test_reset();
    test_basic();
    test_tie_gaps();
    test_no_spike();
    test_saturation();
    test_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
